// File: rtl/upe_pkg.sv
// Shared UPE datapath types and constants.
package upe_pkg;

    localparam int UPE_WIDTH = 32;

    typedef logic [UPE_WIDTH-1:0] upe_word_t;

    localparam upe_word_t UPE_MIN_NEG = {1'b1, {(UPE_WIDTH-1){1'b0}}};
    localparam upe_word_t UPE_MAX_POS = {1'b0, {(UPE_WIDTH-1){1'b1}}};

endpackage

// File: rtl/upe_abs_core.sv
// Combinational two's-complement |x| with sign and most-negative flags.
// Define UPE_ABS_SAT_EN to clamp |MIN_NEG| to MAX_POS instead of wrapping.
module upe_abs_core
    import upe_pkg::*;
#(
    parameter int WIDTH = UPE_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag,
    output logic             neg,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] negx;

    assign neg  = x[WIDTH-1];
    assign ovf  = (x == MIN_NEG);
    assign negx = ~x + WIDTH'(1);

`ifdef UPE_ABS_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    assign mag = ovf ? MAX_POS : (neg ? negx : x);
`else
    // MIN_NEG negates to itself, which is the intended wraparound result
    assign mag = neg ? negx : x;
`endif

endmodule

// File: rtl/upe_abs_signed.sv
// Registered absolute-value stage with a single-entry valid/ready pipeline.
// Saturation of the most-negative operand is enabled by UPE_ABS_SAT_EN.
module upe_abs_signed
    import upe_pkg::*;
#(
    parameter int WIDTH = UPE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_neg,
    output logic             out_ovf
);

    logic [1:0]       vld_pipe;
    logic [WIDTH-1:0] mag;
    logic             neg, ovf;

    upe_abs_core #(.WIDTH(WIDTH)) u_core (
        .x   (in_data),
        .mag (mag),
        .neg (neg),
        .ovf (ovf)
    );

    assign in_ready    = !vld_pipe[1] || out_ready;
    assign vld_pipe[0] = in_valid && in_ready;
    assign out_valid   = vld_pipe[1];

    // Valid only advances when the slot is free or draining; otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            out_data    <= '0;
            out_neg     <= 1'b0;
            out_ovf     <= 1'b0;
        end else begin
            if (in_ready)
                vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                out_data <= mag;
                out_neg  <= neg;
                out_ovf  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_upe_abs_signed.sv
// Self-checking bench for upe_abs_signed: vector table, directed corners, random vs model.
module tb_upe_abs_signed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    upe_abs_signed #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] mag;
        logic        neg;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: signed integer magnitude, then fit into 32 bits.
    function automatic vec_t ref_abs(input logic [31:0] x);
        vec_t   r;
        longint v, m;
        v = longint'($signed(x));
        m = (v < 0) ? -v : v;
        r.din = x;
        r.neg = (v < 0);
        r.ovf = (m > 64'sd2147483647);
`ifdef UPE_ABS_SAT_EN
        r.mag = r.ovf ? 32'h7FFF_FFFF : m[31:0];
`else
        r.mag = m[31:0];
`endif
        return r;
    endfunction

    vec_t tbl[10];
    vec_t q[$];
    vec_t e;

    initial begin
`ifdef UPE_ABS_SAT_EN
        logic [31:0] min_mag = 32'h7FFF_FFFF;
`else
        logic [31:0] min_mag = 32'h8000_0000;
`endif
        logic ordy, ivld, fire_in, fire_out;
        logic [31:0] d;

        tbl[0] = '{32'hCB2A_EACF, 32'h34D5_1531, 1'b1, 1'b0};
        tbl[1] = '{32'h34D5_1531, 32'h34D5_1531, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
        tbl[4] = '{32'h8000_0000, min_mag,       1'b1, 1'b1};
        tbl[5] = '{32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0};
        tbl[7] = '{32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0};
        tbl[9] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data,       32'd0);
        chk("rst_flags", {30'd0, out_neg, out_ovf}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Back-to-back streaming through the table: result of i checked as i+1 is driven.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = tbl[i].din; out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i),  out_data, tbl[i].mag);
            chk($sformatf("vec%0d_flags", i), {30'd0, out_neg, out_ovf}, {30'd0, tbl[i].neg, tbl[i].ovf});
        end

        // Drain with no new input: valid drops, data holds.
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold",  out_data, 32'h0000_0001);

        // Backpressure
        in_valid = 1'b1; in_data = 32'hFFFF_FFF0; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_first", out_data, 32'h0000_0010);
        in_data = 32'h0001_2345;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_data", i),  out_data, 32'h0000_0010);
            chk($sformatf("bp%0d_flags", i), {30'd0, out_neg, out_ovf}, 32'd2);
        end
        out_ready = 1'b1; in_data = 32'hFFFF_FF00;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_swap_valid", 32'(out_valid), 32'd1);
        chk("bp_swap_data",  out_data, 32'h0000_0100);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Random traffic against a queue-based model
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_data",  out_data, q[0].mag);
                chk("rnd_flags", {30'd0, out_neg, out_ovf}, {30'd0, q[0].neg, q[0].ovf});
            end
            ivld = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: d = 32'h8000_0000;
                1: d = 32'h0000_0000;
                2: d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            in_valid = ivld; in_data = d; out_ready = ordy;
            fire_out = (q.size() != 0) && ordy;
            fire_in  = ivld && ((q.size() == 0) || ordy);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'((q.size() == 0) || ordy));
            if (fire_out) void'(q.pop_front());
            if (fire_in)  q.push_back(ref_abs(d));
            @(negedge clk);
        end

        // Asynchronous reset with a held result, away from any rising edge
        in_valid = 1'b1; in_data = 32'hFFFF_FFFB; out_ready = 1'b0;
        @(negedge clk);
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data",  out_data, 32'd0);
        chk("mr_flags", {30'd0, out_neg, out_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_data = 32'hCB2A_EACF; out_ready = 1'b1;
        @(negedge clk);
        chk("mr_first_valid", 32'(out_valid), 32'd1);
        chk("mr_first_data",  out_data, 32'h34D5_1531);
        e = ref_abs(32'hCB2A_EACF);
        chk("mr_first_model", out_data, e.mag);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
